// File: rtl/awmf_chain_shifter.sv
// ---------------------------------------------------------------------------
// awmf_chain_shifter
//
// Serial engine for the AWMF-0165 daisy chain (4 devices x 60 bits = 240-bit
// frame). A frame handed over by the chain controller is shifted MSB-first
// onto SCLK/SDI while SDO is captured into a readback word. Write
// transactions finish with an LDB latch pulse; read transactions do not.
//
// Ports:
//   clk_i          system clock, all logic on posedge
//   rst_i          synchronous active-high reset
//   chain_wr_en_i  start pulse, only honoured while idle
//   chain_wr_i     1 = write (latch at end), 0 = read; captured at start
//   chain_data_i   frame to shift, bit CHAIN_BITS-1 goes out first
//   chain_data_o   readback frame, first received bit lands in the MSB
//   chain_busy_o   high for the whole transaction
//   spi_sclk_o     serial clock to the chain, idle low
//   spi_sdi_o      serial data to the first device
//   spi_sdo_i      serial data from the last device
//   spi_ldb_o      load strobe, active high
//
// Optional feature macro: AWMF_CHAIN_LOOPBACK_EN
//   When defined, spi_sdo_i is ignored and the receive shifter is fed from
//   the registered spi_sdi_o, so a completed frame reads back exactly what
//   was transmitted. Pins keep toggling normally.
// ---------------------------------------------------------------------------
module awmf_chain_shifter #(
    parameter int CHAIN_BITS   = 240,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  chain_wr_en_i,
    input  logic                  chain_wr_i,
    input  logic [CHAIN_BITS-1:0] chain_data_i,
    output logic [CHAIN_BITS-1:0] chain_data_o,
    output logic                  chain_busy_o,
    output logic                  spi_sclk_o,
    output logic                  spi_sdi_o,
    input  logic                  spi_sdo_i,
    output logic                  spi_ldb_o
);

    // Bit counter must be able to hold CHAIN_BITS itself.
    localparam int BCNT_W = $clog2(CHAIN_BITS + 1);

    // One shared cycle counter serves the SCLK half-periods, the latch
    // width and the gap, so it is sized for the largest of the three.
    localparam int CMAX_A = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
    localparam int CMAX   = (CMAX_A > GAP_CYCLES) ? CMAX_A : GAP_CYCLES;
    localparam int DCNT_W = $clog2(CMAX + 1);

    localparam logic [DCNT_W-1:0] DCNT_ZERO  = DCNT_W'(0);
    localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DIV_LAST   = DCNT_W'(CLK_DIV - 1);
    localparam logic [DCNT_W-1:0] LATCH_LAST = DCNT_W'(LATCH_CYCLES - 1);
    localparam logic [DCNT_W-1:0] GAP_LAST   = DCNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    localparam logic [BCNT_W-1:0] BCNT_ZERO = BCNT_W'(0);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] BITS_LAST = BCNT_W'(CHAIN_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    state_t                  state_r;
    logic [CHAIN_BITS-1:0]   tx_r;
    logic [CHAIN_BITS-1:0]   rx_r;
    logic [CHAIN_BITS-1:0]   data_r;
    logic                    mode_wr_r;
    logic [BCNT_W-1:0]       bit_cnt_r;
    logic [DCNT_W-1:0]       div_cnt_r;
    logic                    busy_r;
    logic                    sclk_r;
    logic                    sdi_r;
    logic                    ldb_r;

    logic                    rx_in_s;
    logic [CHAIN_BITS-1:0]   rx_next_s;
    logic [CHAIN_BITS-1:0]   rx_final_s;
    logic                    div_done_s;
    logic                    latch_done_s;
    logic                    gap_done_s;
    logic                    last_bit_s;

`ifdef AWMF_CHAIN_LOOPBACK_EN
    // SDO pin is deliberately left unconnected in loopback builds.
    logic unused_sdo_s;
    assign unused_sdo_s = spi_sdo_i;
`endif

    // State after the last bit of a frame: latch for writes, otherwise gap
    // (or straight back to idle when no gap is configured).
    function automatic state_t after_frame(input logic wr);
        state_t nxt;
        if (wr) begin
            nxt = ST_LATCH;
        end else if (GAP_CYCLES > 0) begin
            nxt = ST_GAP;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

    // State after the latch pulse.
    function automatic state_t after_latch();
        state_t nxt;
        if (GAP_CYCLES > 0) begin
            nxt = ST_GAP;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

    // Receive path selection and shift/termination decodes.
    always_comb begin
        rx_in_s      = 1'b0;
`ifdef AWMF_CHAIN_LOOPBACK_EN
        rx_in_s      = sdi_r;
`else
        rx_in_s      = spi_sdo_i;
`endif
        rx_next_s    = {rx_r[CHAIN_BITS-2:0], rx_in_s};
        div_done_s   = (div_cnt_r == DIV_LAST);
        latch_done_s = (div_cnt_r == LATCH_LAST);
        gap_done_s   = (div_cnt_r == GAP_LAST);
        last_bit_s   = (bit_cnt_r == BITS_LAST);
        // With CLK_DIV == 1 the sample and the half-period exit share one
        // cycle, so the completed word must include the bit sampled now.
        if (div_cnt_r == DCNT_ZERO) begin
            rx_final_s = rx_next_s;
        end else begin
            rx_final_s = rx_r;
        end
    end

    // Transaction FSM with all pin and status outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            tx_r      <= '0;
            rx_r      <= '0;
            data_r    <= '0;
            mode_wr_r <= 1'b0;
            bit_cnt_r <= BCNT_ZERO;
            div_cnt_r <= DCNT_ZERO;
            busy_r    <= 1'b0;
            sclk_r    <= 1'b0;
            sdi_r     <= 1'b0;
            ldb_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sclk_r    <= 1'b0;
                    sdi_r     <= 1'b0;
                    ldb_r     <= 1'b0;
                    div_cnt_r <= DCNT_ZERO;
                    if (chain_wr_en_i) begin
                        tx_r      <= chain_data_i;
                        mode_wr_r <= chain_wr_i;
                        busy_r    <= 1'b1;
                        state_r   <= ST_LOAD;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    sdi_r     <= tx_r[CHAIN_BITS-1];
                    bit_cnt_r <= BCNT_ZERO;
                    div_cnt_r <= DCNT_ZERO;
                    state_r   <= ST_SHIFT_LO;
                end

                ST_SHIFT_LO: begin
                    if (div_done_s) begin
                        sclk_r    <= 1'b1;
                        div_cnt_r <= DCNT_ZERO;
                        state_r   <= ST_SHIFT_HI;
                    end else begin
                        div_cnt_r <= div_cnt_r + DCNT_ONE;
                    end
                end

                ST_SHIFT_HI: begin
                    // SDO is sampled once, on the first high cycle.
                    if (div_cnt_r == DCNT_ZERO) begin
                        rx_r <= rx_next_s;
                    end
                    if (div_done_s) begin
                        sclk_r    <= 1'b0;
                        div_cnt_r <= DCNT_ZERO;
                        bit_cnt_r <= bit_cnt_r + BCNT_ONE;
                        if (last_bit_s) begin
                            data_r  <= rx_final_s;
                            sdi_r   <= 1'b0;
                            ldb_r   <= (after_frame(mode_wr_r) == ST_LATCH);
                            busy_r  <= (after_frame(mode_wr_r) != ST_IDLE);
                            state_r <= after_frame(mode_wr_r);
                        end else begin
                            // SDI only moves together with the falling SCLK.
                            tx_r    <= {tx_r[CHAIN_BITS-2:0], 1'b0};
                            sdi_r   <= tx_r[CHAIN_BITS-2];
                            state_r <= ST_SHIFT_LO;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DCNT_ONE;
                    end
                end

                ST_LATCH: begin
                    sclk_r <= 1'b0;
                    sdi_r  <= 1'b0;
                    if (latch_done_s) begin
                        ldb_r     <= 1'b0;
                        div_cnt_r <= DCNT_ZERO;
                        busy_r    <= (after_latch() != ST_IDLE);
                        state_r   <= after_latch();
                    end else begin
                        div_cnt_r <= div_cnt_r + DCNT_ONE;
                    end
                end

                ST_GAP: begin
                    sclk_r <= 1'b0;
                    sdi_r  <= 1'b0;
                    ldb_r  <= 1'b0;
                    if (gap_done_s) begin
                        div_cnt_r <= DCNT_ZERO;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        div_cnt_r <= div_cnt_r + DCNT_ONE;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    sclk_r    <= 1'b0;
                    sdi_r     <= 1'b0;
                    ldb_r     <= 1'b0;
                    div_cnt_r <= DCNT_ZERO;
                    bit_cnt_r <= BCNT_ZERO;
                end
            endcase
        end
    end

    assign chain_data_o = data_r;
    assign chain_busy_o = busy_r;
    assign spi_sclk_o   = sclk_r;
    assign spi_sdi_o    = sdi_r;
    assign spi_ldb_o    = ldb_r;

endmodule

// File: tb/tb_awmf_chain_shifter.sv
// ---------------------------------------------------------------------------
// tb_awmf_chain_shifter
//
// Scoreboard bench for awmf_chain_shifter (default parameters). The driver
// pushes one expected-transaction record per frame it starts; a monitor
// watches the serial pins every cycle and, when busy falls, pops the record
// and compares busy width, SCLK edge count, SDI bit order, LDB width/timing
// and the readback word. Also honours AWMF_CHAIN_LOOPBACK_EN.
// ---------------------------------------------------------------------------
module tb_awmf_chain_shifter;

    localparam int NB = 240;
`ifdef AWMF_CHAIN_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          wr_en;
    logic          wr;
    logic [NB-1:0] din;
    logic [NB-1:0] dout;
    logic          busy;
    logic          sclk;
    logic          sdi;
    logic          sdo;
    logic          ldb;

    always #5 clk = ~clk;

    awmf_chain_shifter dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .chain_wr_en_i (wr_en),
        .chain_wr_i    (wr),
        .chain_data_i  (din),
        .chain_data_o  (dout),
        .chain_busy_o  (busy),
        .spi_sclk_o    (sclk),
        .spi_sdi_o     (sdi),
        .spi_sdo_i     (sdo),
        .spi_ldb_o     (ldb)
    );

    typedef struct {
        logic [NB-1:0] tx;
        logic [NB-1:0] rx;
        logic          wr;
        logic          abort;
        int            busy_len;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // SDO model: presents the pattern MSB-first, advancing on each SCLK fall.
    logic [NB-1:0] sdo_pat = '0;
    int            sdo_idx = 0;
    bit            sdo_en  = 1'b1;

    always @(negedge sclk) begin
        if (sdo_en && sdo_idx < NB - 1) begin
            sdo_idx++;
            sdo = sdo_pat[NB-1-sdo_idx];
        end
    end

    task automatic sdo_arm(input logic [NB-1:0] pat);
        sdo_pat = pat;
        sdo_idx = 0;
        sdo     = pat[NB-1];
    endtask

    function automatic logic [NB-1:0] exp_rx(input logic [NB-1:0] tx, input logic [NB-1:0] pat);
        return LOOPBACK ? tx : pat;
    endfunction

    // Monitor: per-frame pin statistics, compared against the queue head.
    int   m_cyc = 0, m_busy = 0, m_rises = 0, m_ldb = 0, m_sdi_err = 0;
    int   m_ldb_first = -1, m_last_fall = -2;
    logic p_busy = 1'b0, p_sclk = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        m_cyc++;
        if (busy === 1'b1 && p_busy !== 1'b1) begin
            m_busy = 0; m_rises = 0; m_ldb = 0; m_sdi_err = 0;
            m_ldb_first = -1; m_last_fall = -2;
        end
        if (busy === 1'b1) begin
            m_busy++;
            if (sclk === 1'b1 && p_sclk === 1'b0) begin
                if (q.size() > 0 && m_rises < NB) begin
                    if (sdi !== q[0].tx[NB-1-m_rises]) m_sdi_err++;
                end
                m_rises++;
            end
            if (sclk === 1'b0 && p_sclk === 1'b1) m_last_fall = m_cyc;
            if (ldb === 1'b1) begin
                if (m_ldb == 0) m_ldb_first = m_cyc;
                m_ldb++;
            end
        end
        if (busy === 1'b0 && p_busy === 1'b1) begin
            chk_i("frame_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_i("sdi_bits", m_sdi_err, 0);
                if (e.abort) begin
                    chk_i("abort_ldb", m_ldb, 0);
                    chk("abort_data", dout, '0);
                end else begin
                    chk_i("busy_len", m_busy, e.busy_len);
                    chk_i("sclk_rises", m_rises, NB);
                    chk_i("ldb_len", m_ldb, e.wr ? 4 : 0);
                    if (e.wr) chk_i("ldb_after_fall", m_ldb_first, m_last_fall);
                    chk("rx_data", dout, e.rx);
                end
            end
        end
        p_busy = busy;
        p_sclk = sclk;
    end

    task automatic push(input logic [NB-1:0] tx, input logic w, input logic ab);
        exp_t e;
        e.tx       = tx;
        e.rx       = exp_rx(tx, sdo_pat);
        e.wr       = w;
        e.abort    = ab;
        e.busy_len = w ? 1927 : 1923;
        q.push_back(e);
    endtask

    task automatic start(input logic [NB-1:0] tx, input logic w);
        @(negedge clk);
        din   = tx;
        wr    = w;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles", busy, budget);
        end
    endtask

    logic [NB-1:0] pat_a5, pat_3c, pat_rd, tx_a, tx_b, tx_c, tx_d;

    initial begin
        int act;
        int n;
        pat_a5 = {30{8'hA5}};
        pat_3c = {30{8'h3C}};
        pat_rd = {48'h0123456789AB, {3{64'h0123456789ABCDEF}}};
        tx_a   = {8{30'h2AC3_0F91}};
        tx_b   = {6{40'hF0_1234_5ABC}};
        tx_c   = {15{16'hBEEF}};
        tx_d   = {10{24'h69_C3A5}};

        rst_i = 1'b1; wr_en = 1'b0; wr = 1'b0; din = '0; sdo = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", dout, '0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_sclk", int'(sclk), 0);
        chk_i("rst_sdi", int'(sdi), 0);
        chk_i("rst_ldb", int'(ldb), 0);
        rst_i = 1'b0;

        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (sclk !== 1'b0 || busy !== 1'b0 || ldb !== 1'b0 || sdi !== 1'b0) act++;
        end
        chk_i("idle_quiet", act, 0);

        // Write of A5 pattern, SDO returns 3C pattern.
        sdo_arm(pat_3c);
        push(pat_a5, 1'b1, 1'b0);
        start(pat_a5, 1'b1);
        wait_idle(3000);
        repeat (10) @(negedge clk);
        chk("data_hold", dout, exp_rx(pat_a5, pat_3c));

        // Read with counting pattern on SDO.
        sdo_arm(pat_rd);
        push(tx_a, 1'b0, 1'b0);
        start(tx_a, 1'b0);
        wait_idle(3000);
        chk_i("read_no_ldb", int'(ldb), 0);

        // Start held high through a read: one frame, then immediate restart.
        repeat (5) @(negedge clk);
        sdo_arm(pat_3c);
        push(tx_a, 1'b0, 1'b0);
        push(tx_b, 1'b1, 1'b0);
        din = tx_a; wr = 1'b0; wr_en = 1'b1;
        @(negedge clk);
        din = tx_b; wr = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_i("held_frame_ends", int'(busy), 0);
        sdo_arm(pat_3c);
        @(negedge clk);
        chk_i("restart_immediate", int'(busy), 1);
        wr_en = 1'b0;
        repeat (3) begin
            repeat (100) @(negedge clk);
            wr_en = 1'b1;
            @(negedge clk);
            wr_en = 1'b0;
        end
        wait_idle(3000);
        repeat (20) @(negedge clk);
        chk_i("no_extra_frame", int'(busy), 0);
        chk_i("queue_drained", q.size(), 0);

        // Reset around bit 100 of a write.
        sdo_arm(pat_rd);
        push(tx_c, 1'b1, 1'b1);
        start(tx_c, 1'b1);
        n = 0;
        while (m_rises < 100 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_i("reached_bit100", int'(m_rises >= 100), 1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk_i("abort_sclk", int'(sclk), 0);
        chk_i("abort_busy", int'(busy), 0);
        chk("abort_dout", dout, '0);
        act = 0;
        repeat (10) begin
            if (ldb !== 1'b0) act++;
            @(negedge clk);
        end
        chk_i("abort_ldb_quiet", act, 0);

        // Normal write after the abort.
        sdo_arm(pat_rd);
        push(tx_d, 1'b1, 1'b0);
        start(tx_d, 1'b1);
        wait_idle(3000);

        if (LOOPBACK) begin
            logic [NB-1:0] rnd;
            for (int i = 0; i < NB / 8; i++) rnd[i*8 +: 8] = 8'($urandom);
            sdo_en = 1'b0;
            sdo    = 1'b1;
            push(rnd, 1'b1, 1'b0);
            start(rnd, 1'b1);
            wait_idle(3000);
        end

        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_i("final_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
